calc_ctrl: RTL and testbench

Sequencing controller for the keypad calculator. Consumes the decoded key levels from the keypad interface, debounces them and turns each press into a single event. Runs the operand/operator/equals entry state machine, accumulates two decimal operands in binary and computes A+B or A-B. Drives a signed binary display value to the downstream BCD/7-segment path.

---
 rtl/calc_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: debounces decoded key levels into single events,
// runs the A/op/B/equals entry FSM and drives a signed display value.
module calc_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        any_btn,
  input  logic        is_number,
  input  logic        is_op,
  input  logic        is_eq,
  input  logic [3:0]  num_val,
  input  logic [1:0]  op_val,
  output logic        key_evt,
  output logic [15:0] disp_val,
  output logic [1:0]  op_led,
  output logic        result_valid,
  output logic [1:0]  state_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES);
  localparam logic [DW-1:0] DIG_MAX  = DW'(MAX_DIGITS);

  typedef enum logic {ARMED, LOCKED} deb_t;
  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    COMPUTE = 2'd2,
    RESULT  = 2'd3
  } calc_t;

  function automatic logic [15:0] acc_digit(input logic [15:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + {12'd0, d};
  endfunction

  logic [8:0]    code, prev_code, lat_code;
  logic          code_ok, fire;
  deb_t          deb_q, deb_n;
  logic [CW-1:0] cnt_q, cnt_n;

  assign code = {is_number, is_op, is_eq, num_val, op_val};

  always_comb begin
    code_ok = 1'b0;
    case ({is_number, is_op, is_eq})
      3'b100:  code_ok = (num_val <= 4'd9);
      3'b010:  code_ok = (op_val == 2'd1) || (op_val == 2'd2);
      3'b001:  code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
  end

  // Debounce: ARMED counts a stable valid code, LOCKED waits for a stable release
  always_comb begin
    deb_n = deb_q;
    cnt_n = cnt_q;
    fire  = 1'b0;
    case (deb_q)
      ARMED: begin
        if (any_btn && code_ok) begin
          if (cnt_q != '0 && code != prev_code) cnt_n = CW'(1);
          else                                  cnt_n = cnt_q + CW'(1);
          if (cnt_n == DEB_LAST) begin
            fire  = 1'b1;
            deb_n = LOCKED;
            cnt_n = '0;
          end
        end else begin
          cnt_n = '0;
        end
      end
      LOCKED: begin
        if (any_btn) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
          if (cnt_n == DEB_LAST) begin
            deb_n = ARMED;
            cnt_n = '0;
          end
        end
      end
      default: begin
        deb_n = LOCKED;
        cnt_n = '0;
      end
    endcase
  end

  // Reset lands in LOCKED so a key held through reset must be released before it counts
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q     <= LOCKED;
      cnt_q     <= '0;
      prev_code <= '0;
      lat_code  <= '0;
      key_evt   <= 1'b0;
    end else begin
      deb_q     <= deb_n;
      cnt_q     <= cnt_n;
      prev_code <= code;
      key_evt   <= fire;
      if (fire) lat_code <= code;
    end
  end

  logic        l_num, l_op, l_eq;
  logic [3:0]  l_d;
  logic [1:0]  l_opv;
  assign l_num = lat_code[8];
  assign l_op  = lat_code[7];
  assign l_eq  = lat_code[6];
  assign l_d   = lat_code[5:2];
  assign l_opv = lat_code[1:0];

  calc_t              state_q, state_n;
  logic [15:0]        a_q, a_n, b_q, b_n;
  logic [DW-1:0]      cnt_a_q, cnt_a_n, cnt_b_q, cnt_b_n;
  logic [1:0]         op_q, op_n;
  logic signed [15:0] result_q, result_n;
  logic [15:0]        disp_n;

  // Calculator entry FSM, acting on the latched code during the key_evt cycle
  always_comb begin
    state_n  = state_q;
    a_n      = a_q;
    b_n      = b_q;
    cnt_a_n  = cnt_a_q;
    cnt_b_n  = cnt_b_q;
    op_n     = op_q;
    result_n = result_q;
    case (state_q)
      ENTER_A: begin
        if (key_evt && l_num && cnt_a_q < DIG_MAX) begin
          a_n     = acc_digit(a_q, l_d);
          cnt_a_n = cnt_a_q + DW'(1);
        end else if (key_evt && l_op) begin
          op_n    = l_opv;
          state_n = ENTER_B;
        end
      end
      ENTER_B: begin
        if (key_evt && l_num && cnt_b_q < DIG_MAX) begin
          b_n     = acc_digit(b_q, l_d);
          cnt_b_n = cnt_b_q + DW'(1);
        end else if (key_evt && l_op && cnt_b_q == '0) begin
          op_n = l_opv;
        end else if (key_evt && l_eq && cnt_b_q != '0) begin
          state_n = COMPUTE;
        end
      end
      COMPUTE: begin
        if (op_q == 2'd2) result_n = $signed(a_q) - $signed(b_q);
        else              result_n = $signed(a_q) + $signed(b_q);
        state_n = RESULT;
      end
      RESULT: begin
        if (key_evt && l_num) begin
          a_n     = {12'd0, l_d};
          b_n     = '0;
          cnt_a_n = DW'(1);
          cnt_b_n = '0;
          op_n    = 2'd0;
          state_n = ENTER_A;
        end
      end
      default: state_n = ENTER_A;
    endcase
  end

  always_comb begin
    disp_n = result_q;
    case (state_q)
      ENTER_A: disp_n = a_q;
      ENTER_B: disp_n = (cnt_b_q == '0) ? a_q : b_q;
      default: disp_n = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ENTER_A;
      a_q          <= '0;
      b_q          <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      op_q         <= '0;
      result_q     <= '0;
      disp_val     <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_n;
      a_q          <= a_n;
      b_q          <= b_n;
      cnt_a_q      <= cnt_a_n;
      cnt_b_q      <= cnt_b_n;
      op_q         <= op_n;
      result_q     <= result_n;
      disp_val     <= disp_n;
      result_valid <= (state_q == COMPUTE);
    end
  end

  assign op_led  = (state_q == ENTER_A) ? 2'd0 : op_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scenario bench for calc_ctrl with DEB_CYCLES=4: expected display values are
// queued at each press and compared once the keypress has settled.
module tb_calc_ctrl;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        any_btn = 1'b0, is_number = 1'b0, is_op = 1'b0, is_eq = 1'b0;
  logic [3:0]  num_val = 4'd0;
  logic [1:0]  op_val = 2'd0;
  logic        key_evt, result_valid;
  logic [15:0] disp_val;
  logic [1:0]  op_led, state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int evts, evt_at, rv_cnt;
  logic [15:0] exp_q[$];

  calc_ctrl #(.DEB_CYCLES(DEB), .MAX_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .any_btn(any_btn), .is_number(is_number),
    .is_op(is_op), .is_eq(is_eq), .num_val(num_val), .op_val(op_val),
    .key_evt(key_evt), .disp_val(disp_val), .op_led(op_led),
    .result_valid(result_valid), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic drive_key(input int kind, input int v);
    any_btn   = 1'b1;
    is_number = (kind == 0);
    is_op     = (kind == 1);
    is_eq     = (kind == 2);
    num_val   = (kind == 0) ? 4'(v) : 4'd0;
    op_val    = (kind == 1) ? 2'(v) : 2'd0;
  endtask

  task automatic release_keys();
    any_btn = 1'b0; is_number = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    num_val = 4'd0; op_val = 2'd0;
  endtask

  task automatic tick(input int idx);
    @(posedge clk); #1;
    if (key_evt) begin
      if (evt_at < 0) evt_at = idx;
      evts++;
    end
    if (result_valid) rv_cnt++;
  endtask

  task automatic press(input int kind, input int v, input int hold, input int exp_evts,
                       input logic [15:0] exp_disp, input logic [1:0] exp_state);
    logic [15:0] want;
    exp_q.push_back(exp_disp);
    evts = 0; evt_at = -1;
    drive_key(kind, v);
    for (int i = 0; i < hold; i++) tick(i);
    release_keys();
    for (int i = 0; i < 6; i++) tick(100 + i);
    n_cmp++;
    if (evts !== exp_evts) begin
      n_bad++; $display("FAIL evt_count key=%0d/%0d got %0d want %0d", kind, v, evts, exp_evts);
    end
    if (exp_evts == 1) begin
      n_cmp++;
      if (evt_at !== DEB - 1) begin
        n_bad++; $display("FAIL evt_latency key=%0d/%0d got %0d want %0d", kind, v, evt_at, DEB - 1);
      end
    end
    want = exp_q.pop_front();
    n_cmp++;
    if (disp_val !== want) begin
      n_bad++; $display("FAIL disp key=%0d/%0d got %h want %h", kind, v, disp_val, want);
    end
    n_cmp++;
    if (state_o !== exp_state) begin
      n_bad++; $display("FAIL state key=%0d/%0d got %0d want %0d", kind, v, state_o, exp_state);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if ({key_evt, disp_val, op_led, result_valid, state_o} !== 21'd0) begin
      n_bad++;
      $display("FAIL %s_outputs got evt=%b disp=%h op=%0d rv=%b st=%0d want all 0",
               tag, key_evt, disp_val, op_led, result_valid, state_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    for (int i = 0; i < DEB + 2; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_key();
    press(0, 7, 10, 1, 16'd7, 2'd0);
  endtask

  task automatic test_bounce();
    evts = 0; evt_at = -1;
    drive_key(0, 5);
    for (int i = 0; i < 3; i++) tick(i);
    release_keys();
    for (int i = 0; i < 3; i++) tick(i);
    drive_key(0, 5);
    for (int i = 0; i < 2; i++) tick(i);
    drive_key(0, 6);
    for (int i = 0; i < 3; i++) tick(i);
    release_keys();
    for (int i = 0; i < 6; i++) tick(i);
    n_cmp++;
    if (evts !== 0) begin n_bad++; $display("FAIL bounce_evts got %0d want 0", evts); end
    n_cmp++;
    if (disp_val !== 16'd7) begin n_bad++; $display("FAIL bounce_disp got %h want 0007", disp_val); end
  endtask

  task automatic test_add();
    rv_cnt = 0;
    press(0, 1, 8, 1, 16'd1, 2'd0);
    press(0, 2, 8, 1, 16'd12, 2'd0);
    press(1, 1, 8, 1, 16'd12, 2'd1);
    n_cmp++;
    if (op_led !== 2'd1) begin n_bad++; $display("FAIL add_opled got %0d want 1", op_led); end
    press(0, 3, 8, 1, 16'd3, 2'd1);
    press(0, 4, 8, 1, 16'd34, 2'd1);
    press(2, 0, 8, 1, 16'd46, 2'd3);
    n_cmp++;
    if (rv_cnt !== 1) begin n_bad++; $display("FAIL add_result_valid got %0d want 1", rv_cnt); end
    n_cmp++;
    if (op_led !== 2'd1) begin n_bad++; $display("FAIL add_opled_result got %0d want 1", op_led); end
  endtask

  task automatic test_sub_and_limit();
    press(0, 5, 8, 1, 16'd5, 2'd0);
    press(1, 2, 8, 1, 16'd5, 2'd1);
    press(0, 1, 8, 1, 16'd1, 2'd1);
    press(0, 2, 8, 1, 16'd12, 2'd1);
    press(2, 0, 8, 1, 16'hFFF9, 2'd3);
    n_cmp++;
    if (op_led !== 2'd2) begin n_bad++; $display("FAIL sub_opled got %0d want 2", op_led); end
    press(0, 9, 8, 1, 16'd9, 2'd0);
    press(0, 9, 8, 1, 16'd99, 2'd0);
    press(0, 9, 8, 1, 16'd999, 2'd0);
    press(0, 9, 8, 1, 16'd9999, 2'd0);
    press(0, 9, 8, 1, 16'd9999, 2'd0);
    n_cmp++;
    if (op_led !== 2'd0) begin n_bad++; $display("FAIL limit_opled got %0d want 0", op_led); end
  endtask

  task automatic test_op_replace();
    press(1, 1, 8, 1, 16'd0, 2'd1);
    press(1, 2, 8, 1, 16'd0, 2'd1);
    n_cmp++;
    if (op_led !== 2'd2) begin n_bad++; $display("FAIL replace_opled got %0d want 2", op_led); end
    press(2, 0, 8, 1, 16'd0, 2'd1);
    press(0, 3, 8, 1, 16'd3, 2'd1);
    press(2, 0, 8, 1, 16'hFFFD, 2'd3);
  endtask

  task automatic test_reset_mid_entry();
    press(0, 5, 8, 1, 16'd5, 2'd0);
    press(1, 1, 8, 1, 16'd5, 2'd1);
    evts = 0; evt_at = -1;
    drive_key(0, 3);
    tick(0); tick(1);
    n_cmp++;
    if (state_o !== 2'd1) begin n_bad++; $display("FAIL midreset_pre_state got %0d want 1", state_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick(i);
    release_keys();
    for (int i = 0; i < 6; i++) tick(i);
    n_cmp++;
    if (evts !== 0) begin n_bad++; $display("FAIL midreset_held_evts got %0d want 0", evts); end
    n_cmp++;
    if (disp_val !== 16'd0) begin n_bad++; $display("FAIL midreset_disp got %h want 0000", disp_val); end
    press(0, 3, 8, 1, 16'd3, 2'd0);
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_reset();
    test_add();
    test_sub_and_limit();
    test_reset();
    test_op_replace();
    test_reset_mid_entry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
